// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard
//
// Hazard / forwarding scoreboard for the in-order pipeline. Tracks the
// destination register of every instruction in the STAGES stages after ID
// (stage 1 = EX, stage STAGES = WB, which writes the register file at the end
// of its cycle). Produces the ID/PC hold, the ID/EX bubble and registered
// operand-forwarding selects for the EX muxes, plus an in-flight count.
//
// Forwarding select encoding, valid while the consumer sits in stage 1:
//   0            register file / ID/EX operand value
//   j (2..STAGES) result currently held in stage j
//   STAGES+1     retire buffer (producer wrote the RF on the edge ID read it)
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   id_valid     instruction present in ID
//   id_rs1/rs2   source addresses, id_rs1_used/id_rs2_used qualify them
//   id_rd        destination address, id_we: instruction writes id_rd
//   id_is_load   instruction is a load
//   flush        branch taken in EX, kills the ID instruction
//   ext_hold     memory-side freeze of the whole pipeline
//   stall        hold PC and IF/ID (combinational)
//   bubble       ID/EX loads a NOP this cycle (combinational)
//   fwd_a/fwd_b  EX source-1/source-2 forwarding selects (registered)
//   inflight     number of valid tracked entries (registered)
//
// Optional build macro SCOREBOARD_STATS_EN adds stat_stall / stat_flush,
// 32-bit saturating counts of hazard-stall cycles and flush cycles (cycles
// under ext_hold are not counted).

module pipe_scoreboard #(
    parameter  int STAGES     = 3,
    parameter  int REG_AW     = 5,
    parameter  int LOAD_STAGE = 2,
    localparam int SEL_W      = $clog2(STAGES + 2),
    localparam int CNT_W      = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              ext_hold,
    output logic              stall,
    output logic              bubble,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic [CNT_W-1:0]  inflight
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]       stat_stall,
    output logic [31:0]       stat_flush
`endif
);

    logic [STAGES:1]   e_valid;
    logic [STAGES:1]   e_we;
    logic [STAGES:1]   e_load;
    logic [REG_AW-1:0] e_rd [1:STAGES];

    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic              hz_a;
    logic              hz_b;
    logic              hazard;
    logic              issue;
    logic              retire;

    // Scan oldest to youngest so the youngest match is the one that sticks.
    // A match in stage k becomes select k+1 once the consumer reaches EX.
    // The retire buffer needs no lookup of its own: a producer in the retire
    // slot has already written the RF before ID reads it, while a producer in
    // stage STAGES naturally maps to the retire-buffer select STAGES+1.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        hz_a  = 1'b0;
        hz_b  = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (id_rs1_used && (id_rs1 != '0) && e_valid[k] && e_we[k] &&
                (e_rd[k] == id_rs1)) begin
                sel_a = SEL_W'(k + 1);
                hz_a  = e_load[k] && (k < LOAD_STAGE);
            end
            if (id_rs2_used && (id_rs2 != '0) && e_valid[k] && e_we[k] &&
                (e_rd[k] == id_rs2)) begin
                sel_b = SEL_W'(k + 1);
                hz_b  = e_load[k] && (k < LOAD_STAGE);
            end
        end
    end

    assign hazard = hz_a | hz_b;
    assign issue  = id_valid & ~hazard & ~flush & ~ext_hold;
    assign retire = e_valid[STAGES];
    assign stall  = ext_hold | (id_valid & hazard & ~flush);
    assign bubble = ~ext_hold & (flush | ~id_valid | hazard);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_valid  <= '0;
            e_we     <= '0;
            e_load   <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                e_rd[k] <= '0;
            end
            fwd_a    <= '0;
            fwd_b    <= '0;
            inflight <= '0;
        end else if (!ext_hold) begin
            for (int k = STAGES; k >= 2; k--) begin
                e_valid[k] <= e_valid[k-1];
                e_we[k]    <= e_we[k-1];
                e_load[k]  <= e_load[k-1];
                e_rd[k]    <= e_rd[k-1];
            end
            e_valid[1] <= issue;
            e_we[1]    <= issue & id_we;
            e_load[1]  <= issue & id_is_load;
            e_rd[1]    <= id_rd;
            fwd_a      <= issue ? sel_a : '0;
            fwd_b      <= issue ? sel_b : '0;
            case ({issue, retire})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

`ifdef SCOREBOARD_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_stall <= '0;
            stat_flush <= '0;
        end else if (!ext_hold) begin
            if (id_valid && hazard && !flush && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
            if (flush && (stat_flush != '1)) begin
                stat_flush <= stat_flush + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Testbench for pipe_scoreboard (STAGES=3, LOAD_STAGE=2). A driver applies
// directed then random instructions and pushes the expected per-cycle outputs
// into a queue; a monitor pops and compares at every falling edge.
// The reference model keeps a list of in-flight instructions with their
// current stage number.

module tb_pipe_scoreboard;

    localparam int STAGES     = 3;
    localparam int REG_AW     = 5;
    localparam int LOAD_STAGE = 2;
    localparam int SEL_W      = $clog2(STAGES + 2);
    localparam int CNT_W      = $clog2(STAGES + 1);

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_we;
    logic              id_is_load;
    logic              flush;
    logic              ext_hold;
    logic              stall;
    logic              bubble;
    logic [SEL_W-1:0]  fwd_a;
    logic [SEL_W-1:0]  fwd_b;
    logic [CNT_W-1:0]  inflight;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0]       stat_stall;
    logic [31:0]       stat_flush;
`endif

    pipe_scoreboard #(
        .STAGES    (STAGES),
        .REG_AW    (REG_AW),
        .LOAD_STAGE(LOAD_STAGE)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .flush      (flush),
        .ext_hold   (ext_hold),
        .stall      (stall),
        .bubble     (bubble),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .inflight   (inflight)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stat_stall (stat_stall),
        .stat_flush (stat_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [REG_AW-1:0] rd;
        bit                we;
        bit                ld;
        int                stage;
    } inst_t;

    typedef struct {
        bit stall;
        bit bubble;
        int fa;
        int fb;
        int cnt;
    } exp_t;

    inst_t pipe_q[$];
    exp_t  exp_q[$];
    int    m_fa;
    int    m_fb;
    int    checks;
    int    errors;
    bit    last_stall;

    // Youngest in-flight writer of src decides the select and whether the
    // value does not exist yet (load still before its data stage).
    task automatic lookup(input logic [REG_AW-1:0] src, input bit used,
                          output int sel, output bit hz);
        int best;
        best = STAGES + 10;
        sel  = 0;
        hz   = 1'b0;
        if (used && src != 0) begin
            foreach (pipe_q[i]) begin
                if (pipe_q[i].we && pipe_q[i].rd == src && pipe_q[i].stage < best) begin
                    best = pipe_q[i].stage;
                    sel  = best + 1;
                    hz   = pipe_q[i].ld && (best < LOAD_STAGE);
                end
            end
        end
    endtask

    task automatic model_clear();
        pipe_q.delete();
        m_fa = 0;
        m_fb = 0;
    endtask

    // Advance the model by one clock edge using the inputs applied this cycle.
    task automatic model_edge();
        int    sa, sb;
        bit    ha, hb, iss;
        inst_t nq[$];
        inst_t n;
        if (!rst_n) begin
            model_clear();
        end else if (!ext_hold) begin
            lookup(id_rs1, id_rs1_used, sa, ha);
            lookup(id_rs2, id_rs2_used, sb, hb);
            iss = id_valid && !(ha || hb) && !flush;
            foreach (pipe_q[i]) begin
                n = pipe_q[i];
                n.stage = n.stage + 1;
                if (n.stage <= STAGES) nq.push_back(n);
            end
            if (iss) begin
                n.rd = id_rd; n.we = id_we; n.ld = id_is_load; n.stage = 1;
                nq.push_back(n);
            end
            pipe_q = nq;
            m_fa = iss ? sa : 0;
            m_fb = iss ? sb : 0;
        end
    endtask

    task automatic step(input bit v, input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                        input bit u1, input bit u2, input logic [REG_AW-1:0] rd,
                        input bit we, input bit ld, input bit fl, input bit hold, input bit rst);
        int   sa, sb;
        bit   ha, hb, hz;
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_we = we; id_is_load = ld; flush = fl; ext_hold = hold; rst_n = rst;
        if (!rst) model_clear();
        lookup(rs1, u1, sa, ha);
        lookup(rs2, u2, sb, hb);
        hz = ha || hb;
        e.stall  = hold || (v && hz && !fl);
        e.bubble = !hold && (fl || !v || hz);
        e.fa     = m_fa;
        e.fb     = m_fb;
        e.cnt    = pipe_q.size();
        last_stall = e.stall;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic alu(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                       input logic [REG_AW-1:0] rs2);
        step(1, rs1, rs2, 1, 1, rd, 1, 0, 0, 0, 1);
    endtask

    task automatic lw(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1);
        step(1, rs1, 0, 1, 0, rd, 1, 1, 0, 0, 1);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall", int'(stall), int'(e.stall));
                chk("bubble", int'(bubble), int'(e.bubble));
                chk("fwd_a", int'(fwd_a), e.fa);
                chk("fwd_b", int'(fwd_b), e.fb);
                chk("inflight", int'(inflight), e.cnt);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [REG_AW-1:0] r1, r2, rd;
        bit u1, u2, we, ld, v, fl, hold;
        checks = 0; errors = 0; last_stall = 0;
        rst_n = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_we = 0; id_is_load = 0; flush = 0; ext_hold = 0;
        model_clear();

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // in reset
        step(1, 3, 4, 1, 1, 2, 1, 0, 0, 0, 0);   // in reset, valid ID
        idle(2);

        // back-to-back ALU forward
        alu(3, 1, 2);
        alu(4, 3, 1);
        idle(4);
        // load-use: one stall cycle, then issue with select 3
        lw(5, 1);
        alu(6, 5, 0);
        alu(6, 5, 0);
        idle(4);
        // retire-buffer forward
        alu(7, 1, 2);
        alu(10, 1, 2);
        alu(11, 2, 1);
        alu(8, 7, 7);
        idle(4);
        // youngest producer wins; r0 never forwards
        alu(9, 1, 2);
        alu(9, 2, 1);
        alu(12, 9, 9);
        alu(0, 1, 1);
        alu(13, 0, 0);
        idle(4);
        // flush during load-use stall
        lw(5, 2);
        step(1, 5, 0, 1, 0, 6, 1, 0, 1, 0, 1);
        idle(4);
        // ext_hold freeze for 3 cycles
        alu(14, 1, 2);
        lw(15, 14);
        step(1, 15, 14, 1, 1, 16, 1, 0, 0, 1, 1);
        step(1, 15, 14, 1, 1, 16, 1, 0, 1, 1, 1);
        step(1, 15, 14, 1, 1, 16, 1, 0, 0, 1, 1);
        alu(16, 15, 14);
        alu(16, 15, 14);
        idle(4);
        // async reset with three in flight, then no false hazard
        lw(17, 1);
        alu(18, 1, 2);
        alu(19, 2, 3);
        step(1, 17, 0, 1, 0, 20, 1, 0, 0, 0, 0);
        step(1, 17, 0, 1, 0, 20, 1, 0, 0, 0, 1);
        alu(21, 17, 19);
        idle(4);

        // random traffic; a stalled instruction stays in ID until it issues
        v = 0; r1 = 0; r2 = 0; rd = 0; u1 = 0; u2 = 0; we = 0; ld = 0;
        for (int i = 0; i < 600; i++) begin
            if (!last_stall) begin
                v  = ($urandom_range(0, 5) != 0);
                r1 = REG_AW'($urandom_range(0, 7));
                r2 = REG_AW'($urandom_range(0, 7));
                rd = REG_AW'($urandom_range(0, 7));
                u1 = ($urandom_range(0, 3) != 0);
                u2 = ($urandom_range(0, 2) != 0);
                we = ($urandom_range(0, 4) != 0);
                ld = ($urandom_range(0, 2) == 0);
            end
            fl   = ($urandom_range(0, 11) == 0);
            hold = ($urandom_range(0, 9) == 0);
            step(v, r1, r2, u1, u2, rd, we, ld, fl, hold, (i != 300));
        end
        idle(2);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
